// File: rtl/msx_slot_bus_master.sv
`timescale 1ns/1ps
// MSX slot bus initiator: valid/ready request -> Z80-style memory cycle on slot pins.
// Latency SETUP+ACTIVE+STROBE+wait+HOLD cycles from acceptance; req_ready only in IDLE.
// slot_nwait stretches STROBE; MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN adds a 255-cycle wait timeout.
module msx_slot_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int ACTIVE_CYC = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        slot_nreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_sltsl,
    input  logic [15:0] req_address,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_error,
    output logic [15:0] slot_a,
    output logic [7:0]  slot_d_out,
    output logic        slot_d_oe,
    input  logic [7:0]  slot_d_in,
    output logic        slot_nmerq,
    output logic        slot_nsltsl,
    output logic        slot_nrd,
    output logic        slot_nwr,
    input  logic        slot_nwait
);

    localparam int S_C  = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
    localparam int A_C  = (ACTIVE_CYC < 1) ? 1 : ACTIVE_CYC;
    localparam int ST_C = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
    localparam int H_C  = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;
    localparam int M1   = (S_C > A_C) ? S_C : A_C;
    localparam int M2   = (ST_C > H_C) ? ST_C : H_C;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CNT_W = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACTIVE = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic               sltsl_q, sltsl_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               nmerq_q, nmerq_d;
    logic               nsltsl_q, nsltsl_d;
    logic               nrd_q, nrd_d;
    logic               nwr_q, nwr_d;
    logic               d_oe_q, d_oe_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               leave_strobe;
    logic               timed_out;
`ifdef MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN
    logic [7:0]         wcnt_q, wcnt_d;
    logic               err_q, err_d;
    logic               rsp_error_q, rsp_error_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        sltsl_d      = sltsl_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        nmerq_d      = nmerq_q;
        nsltsl_d     = nsltsl_q;
        nrd_d        = nrd_q;
        nwr_d        = nwr_q;
        d_oe_d       = d_oe_q;
        rsp_valid_d  = 1'b0;
        rdata_d      = rdata_q;
        ready_d      = ready_q;
        leave_strobe = 1'b0;
        timed_out    = 1'b0;
`ifdef MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN
        wcnt_d       = wcnt_q;
        err_d        = err_q;
        rsp_error_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    sltsl_d = req_sltsl;
                    addr_d  = req_address;
                    wdata_d = req_wdata;
                    ready_d = 1'b0;
                    cnt_d   = CNT_W'(S_C - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    nmerq_d  = 1'b0;
                    nsltsl_d = ~sltsl_q;
                    d_oe_d   = wr_q;
                    cnt_d    = CNT_W'(A_C - 1);
                    state_d  = ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    nwr_d   = ~wr_q;
                    nrd_d   = wr_q;
                    cnt_d   = CNT_W'(ST_C - 1);
                    state_d = STROBE;
`ifdef MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN
                    wcnt_d  = 8'd0;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE: begin
                // Minimum strobe width first; only then does nwait get a say.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (slot_nwait) begin
                    leave_strobe = 1'b1;
                end
`ifdef MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN
                else if (wcnt_q == 8'hFF) begin
                    leave_strobe = 1'b1;
                    timed_out    = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
`endif
                if (leave_strobe) begin
                    nrd_d   = 1'b1;
                    nwr_d   = 1'b1;
                    cnt_d   = CNT_W'(H_C - 1);
                    state_d = HOLD;
                    if (!wr_q && !timed_out) begin
                        rdata_d = slot_d_in;
                    end
`ifdef MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN
                    err_d = timed_out;
`endif
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    nmerq_d     = 1'b1;
                    nsltsl_d    = 1'b1;
                    d_oe_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
`ifdef MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN
                    rsp_error_d = err_q;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge slot_nreset) begin
        if (!slot_nreset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            sltsl_q     <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            nmerq_q     <= 1'b1;
            nsltsl_q    <= 1'b1;
            nrd_q       <= 1'b1;
            nwr_q       <= 1'b1;
            d_oe_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            ready_q     <= 1'b1;
`ifdef MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN
            wcnt_q      <= 8'd0;
            err_q       <= 1'b0;
            rsp_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            sltsl_q     <= sltsl_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            nmerq_q     <= nmerq_d;
            nsltsl_q    <= nsltsl_d;
            nrd_q       <= nrd_d;
            nwr_q       <= nwr_d;
            d_oe_q      <= d_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
`ifdef MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            rsp_error_q <= rsp_error_d;
`endif
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign slot_a      = addr_q;
    assign slot_d_out  = wdata_q;
    assign slot_d_oe   = d_oe_q;
    assign slot_nmerq  = nmerq_q;
    assign slot_nsltsl = nsltsl_q;
    assign slot_nrd    = nrd_q;
    assign slot_nwr    = nwr_q;
`ifdef MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN
    assign rsp_error   = rsp_error_q;
`else
    assign rsp_error   = 1'b0;
`endif

endmodule

// File: tb/tb_msx_slot_bus_master.sv
`timescale 1ns/1ps
// Directed bench for msx_slot_bus_master: response scoreboard plus slot-pin monitor.
module tb_msx_slot_bus_master;

    logic        clk = 1'b0;
    logic        slot_nreset;
    logic        req_valid, req_ready, req_wr, req_sltsl;
    logic [15:0] req_address;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_error;
    logic [7:0]  rsp_rdata;
    logic [15:0] slot_a;
    logic [7:0]  slot_d_out, slot_d_in;
    logic        slot_d_oe, slot_nmerq, slot_nsltsl, slot_nrd, slot_nwr, slot_nwait;
    logic [7:0]  rsp_byte;

    always #23 clk = ~clk;

    // Responder: drives its data only while the read strobe is low.
    assign slot_d_in = slot_nrd ? 8'h00 : rsp_byte;

    msx_slot_bus_master dut (
        .clk(clk), .slot_nreset(slot_nreset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_sltsl(req_sltsl), .req_address(req_address), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .slot_a(slot_a), .slot_d_out(slot_d_out), .slot_d_oe(slot_d_oe),
        .slot_d_in(slot_d_in), .slot_nmerq(slot_nmerq), .slot_nsltsl(slot_nsltsl),
        .slot_nrd(slot_nrd), .slot_nwr(slot_nwr), .slot_nwait(slot_nwait)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic        sltsl;
        int          slen;
    } bus_t;
    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   total = 0;
    int   bad = 0;
    int   rsp_seen = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Response scoreboard
    rsp_t mon_e;
    initial forever begin
        @(negedge clk);
        if (slot_nreset && rsp_valid) begin
            rsp_seen++;
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 0);
            end else begin
                mon_e = rsp_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                chk("rsp_error", 32'(rsp_error), 32'(mon_e.err));
            end
        end
    end

    // Slot-pin monitor
    bus_t cur;
    logic cur_vld = 1'b0;
    logic prev_nmerq = 1'b1;
    int   slen = 0;
    initial forever begin
        @(negedge clk);
        if (!slot_nreset) begin
            cur_vld = 1'b0;
            slen = 0;
            prev_nmerq = 1'b1;
        end else begin
            if (!slot_nmerq && prev_nmerq) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_merq", 32'(slot_nmerq), 1);
                    cur_vld = 1'b0;
                end else begin
                    cur = bus_q.pop_front();
                    cur_vld = 1'b1;
                end
            end
            if (!slot_nmerq && cur_vld) begin
                chk("slot_a", 32'(slot_a), 32'(cur.addr));
                chk("nsltsl", 32'(slot_nsltsl), 32'(!cur.sltsl));
                chk("d_oe", 32'(slot_d_oe), 32'(cur.wr));
                if (cur.wr) chk("d_out", 32'(slot_d_out), 32'(cur.data));
                chk("ready_busy", 32'(req_ready), 0);
            end
            chk("strobe_excl", 32'(!slot_nrd && !slot_nwr), 0);
            chk("strobe_in_merq", 32'((!slot_nrd || !slot_nwr) && slot_nmerq), 0);
            if (!slot_nrd || !slot_nwr) begin
                slen++;
                if (cur_vld) chk("strobe_kind", 32'(slot_nwr), 32'(!cur.wr));
            end else if (slen > 0) begin
                if (cur_vld && cur.slen >= 0) chk("strobe_len", 32'(slen), 32'(cur.slen));
                slen = 0;
            end
            prev_nmerq = slot_nmerq;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 1);
    endtask

    // Returns at the negedge right after the acceptance edge E0.
    task automatic issue(input logic wr, input logic sl, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] rd, input int sl_len,
                         input logic err, input logic keep);
        bus_t b;
        rsp_t r;
        wait_ready();
        b.addr = a; b.data = d; b.wr = wr; b.sltsl = sl; b.slen = sl_len;
        bus_q.push_back(b);
        if (!wr && !err) last_rd = rd;
        r.rdata = last_rd; r.err = err;
        rsp_q.push_back(r);
        req_wr = wr; req_sltsl = sl; req_address = a; req_wdata = d;
        req_valid = 1'b1;
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (rsp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(rsp_q.size()), 0);
        wait_ready();
    endtask

    logic [7:0] e_merq, e_nwr, e_rv;
    int seen0;

    initial begin
        #(46 * 20000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        slot_nreset = 1'b0; slot_nwait = 1'b1; rsp_byte = 8'h00;
        req_valid = 1'b0; req_wr = 1'b0; req_sltsl = 1'b0;
        req_address = 16'h0000; req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_nmerq", 32'(slot_nmerq), 1);
        chk("rst_nsltsl", 32'(slot_nsltsl), 1);
        chk("rst_nrd", 32'(slot_nrd), 1);
        chk("rst_nwr", 32'(slot_nwr), 1);
        chk("rst_d_oe", 32'(slot_d_oe), 0);
        chk("rst_slot_a", 32'(slot_a), 0);
        chk("rst_d_out", 32'(slot_d_out), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_error", 32'(rsp_error), 0);
        chk("rst_ready", 32'(req_ready), 1);
        slot_nreset = 1'b1;
        @(negedge clk);

        // Write 0x4000/0x64: cycle-exact pin timing after E0+k
        e_merq = 8'b1100_0001;
        e_nwr  = 8'b1110_0011;
        e_rv   = 8'b0100_0000;
        issue(1'b1, 1'b1, 16'h4000, 8'h64, 8'h00, 3, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t1_nmerq_k%0d", k), 32'(slot_nmerq), 32'(e_merq[k]));
            chk($sformatf("t1_nwr_k%0d", k), 32'(slot_nwr), 32'(e_nwr[k]));
            chk($sformatf("t1_rv_k%0d", k), 32'(rsp_valid), 32'(e_rv[k]));
            if (k == 0) chk("t1_slot_a_e0", 32'(slot_a), 32'h4000);
            @(negedge clk);
        end
        drain();

        // Read 0x5000, sltsl=0, responder returns 0xA5
        rsp_byte = 8'hA5;
        issue(1'b0, 1'b0, 16'h5000, 8'h00, 8'hA5, 3, 1'b0, 1'b0);
        drain();

        // Wait insertion: nwait low for 4 cycles from nrd fall, data valid only after
        rsp_byte = 8'h11;
        issue(1'b0, 1'b1, 16'h6001, 8'h00, 8'hC3, 5, 1'b0, 1'b0);
        for (int n = 0; n < 20 && slot_nrd; n++) @(negedge clk);
        chk("t3_nrd_fell", 32'(slot_nrd), 0);
        slot_nwait = 1'b0;
        repeat (4) @(negedge clk);
        slot_nwait = 1'b1;
        rsp_byte = 8'hC3;
        drain();

        // Back-to-back writes with req_valid held high
        for (int i = 0; i < 256; i++)
            issue(1'b1, 1'b1, 16'h5000, 8'(i), 8'h00, 3, 1'b0, 1'b1);
        issue(1'b1, 1'b1, 16'h4001, 8'hFF, 8'h00, 3, 1'b0, 1'b0);
        drain();

        // Reset at E0+3 of a write
        issue(1'b1, 1'b1, 16'h4002, 8'h5A, 8'h00, 3, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 slot_nreset = 1'b0;
        #1;
        chk("t5_nmerq", 32'(slot_nmerq), 1);
        chk("t5_nsltsl", 32'(slot_nsltsl), 1);
        chk("t5_nwr", 32'(slot_nwr), 1);
        chk("t5_nrd", 32'(slot_nrd), 1);
        chk("t5_d_oe", 32'(slot_d_oe), 0);
        rsp_q.delete();
        bus_q.delete();
        last_rd = 8'h00;
        seen0 = rsp_seen;
        @(negedge clk);
        slot_nreset = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_ready", 32'(req_ready), 1);
        chk("t5_no_rsp", 32'(rsp_seen), 32'(seen0));
        chk("t5_rdata", 32'(rsp_rdata), 0);

        // Permanent wait
        rsp_byte = 8'h3C;
        issue(1'b0, 1'b1, 16'h7000, 8'h00, 8'h3C, 3, 1'b0, 1'b0);
        drain();
        rsp_byte = 8'h77;
        slot_nwait = 1'b0;
`ifdef MSX_SLOT_BUS_MASTER_WAIT_TIMEOUT_EN
        issue(1'b0, 1'b1, 16'h7001, 8'h00, 8'h77, 258, 1'b1, 1'b0);
        drain();
        slot_nwait = 1'b1;
`else
        seen0 = rsp_seen;
        issue(1'b0, 1'b1, 16'h7001, 8'h00, 8'h77, -1, 1'b0, 1'b0);
        repeat (1000) @(negedge clk);
        chk("t6_no_rsp_while_wait", 32'(rsp_seen), 32'(seen0));
        slot_nwait = 1'b1;
        drain();
`endif

        chk("bus_q_empty", 32'(bus_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
